// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag/branch unit: condition codes, SZCV bit positions
// and FSM state encoding.
package flag_branch_unit_pkg;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b100;

    // Bit positions inside the ALU's {S,Z,C,V} flag word.
    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StEval  = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch-condition evaluator: resolves a 3-bit condition code
// against an SZCV flag word.
module cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       taken,
    output logic       illegal
);

    logic lt;
    assign lt = flags[FLAG_S] ^ flags[FLAG_V];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (cond)
            COND_BE:  taken = flags[FLAG_Z];
            COND_BLT: taken = lt;
            COND_BLE: taken = flags[FLAG_Z] | lt;
            COND_BNE: taken = ~flags[FLAG_Z];
            COND_B:   taken = 1'b1;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch resolution FSM and program counter; drives redirect
// and flush into fetch.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int unsigned     WIDTH        = 16,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       szcv_in,
    input  logic             flag_we,
    input  logic             pc_en,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] pc,
    output logic [3:0]       flags,
    output logic             taken,
    output logic             flush,
    output logic             illegal
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q;
    logic [2:0]       cond_q;
    logic [3:0]       flags_q;
    logic [3:0]       cnt_q, cnt_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;
    logic [3:0]       eff_flags;
    logic             cond_taken, cond_illegal;
    logic             accept;

    // Forward same-cycle ALU flags so a compare can feed a branch in EVAL.
    assign eff_flags = flag_we ? szcv_in : flags_q;
    assign accept    = br_valid && br_ready;

    cond_eval u_cond_eval (
        .flags   (eff_flags),
        .cond    (cond_q),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            StIdle: begin
                // An accepted branch freezes pc until it resolves.
                if (accept) begin
                    state_d = StEval;
                end else if (pc_en) begin
                    pc_d = pc_q + WIDTH'(1);
                end
            end
            StEval: begin
                illegal_d = cond_illegal;
                if (cond_taken) begin
                    pc_d    = target_q;
                    cnt_d   = 4'(FLUSH_CYCLES);
                    taken_d = 1'b1;
                    state_d = StFlush;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (pc_en) begin
                    pc_d = pc_q + WIDTH'(1);
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            flags_q   <= 4'b0000;
            cnt_q     <= 4'd0;
            cond_q    <= 3'd0;
            target_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            if (flag_we) begin
                flags_q <= szcv_in;
            end
            if (accept) begin
                cond_q   <= br_cond;
                target_q <= br_target;
            end
        end
    end

    assign br_ready = (state_q == StIdle);
    assign flush    = (state_q == StFlush);
    assign pc       = pc_q;
    assign flags    = flags_q;
    assign taken    = taken_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit (WIDTH=16, FLUSH_CYCLES=2).
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  szcv_in;
    logic        flag_we;
    logic        pc_en;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic [3:0]  flags;
    logic        taken;
    logic        flush;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;
    int accepts  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (br_valid && br_ready) accepts++;

    flag_branch_unit #(
        .WIDTH        (16),
        .FLUSH_CYCLES (2),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .szcv_in   (szcv_in),
        .flag_we   (flag_we),
        .pc_en     (pc_en),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_target (br_target),
        .pc        (pc),
        .flags     (flags),
        .taken     (taken),
        .flush     (flush),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; szcv_in = 4'h0; flag_we = 1'b0; pc_en = 1'b0;
        br_valid = 1'b0; br_cond = 3'd0; br_target = 16'h0000;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_flags", flags, 4'h0);
        check("rst_flush", flush, 0);
        check("rst_taken", taken, 0);
        check("rst_illegal", illegal, 0);
        check("rst_ready", br_ready, 1);

        // Compare sets Z, then BE to 0x0040.
        flag_we = 1'b1; szcv_in = 4'b0100;
        step();
        check("be_flags", flags, 4'b0100);
        flag_we = 1'b0; br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h0040;
        step();
        br_valid = 1'b0;
        check("be_eval_ready", br_ready, 0);
        check("be_eval_pc", pc, 16'h0000);
        step();
        check("be_pc", pc, 16'h0040);
        check("be_taken", taken, 1);
        check("be_flush1", flush, 1);
        step();
        check("be_taken_off", taken, 0);
        check("be_flush2", flush, 1);
        step();
        check("be_flush_done", flush, 0);
        check("be_ready", br_ready, 1);

        // BLT with flags forwarded in the EVAL cycle.
        flag_we = 1'b1; szcv_in = 4'b0000;
        step();
        flag_we = 1'b0; br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h0100;
        step();
        br_valid = 1'b0; flag_we = 1'b1; szcv_in = 4'b1000;
        step();
        flag_we = 1'b0;
        check("blt_pc", pc, 16'h0100);
        check("blt_taken", taken, 1);
        check("blt_flags", flags, 4'b1000);
        step(); step();
        check("blt_ready", br_ready, 1);

        // Unconditional branch to 0x0010, then not-taken BNE with Z=1.
        br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0010;
        step();
        br_valid = 1'b0;
        step(); step(); step();
        check("b_pc", pc, 16'h0010);
        flag_we = 1'b1; szcv_in = 4'b0100;
        step();
        flag_we = 1'b0; br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0200;
        step();
        br_valid = 1'b0; pc_en = 1'b1;
        check("bne_eval_ready", br_ready, 0);
        check("bne_eval_pc", pc, 16'h0010);
        step();
        pc_en = 1'b0;
        check("bne_taken", taken, 0);
        check("bne_flush", flush, 0);
        check("bne_pc", pc, 16'h0010);
        check("bne_ready", br_ready, 1);

        // Reserved code, with pc_en in the accept cycle.
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0300; pc_en = 1'b1;
        step();
        br_valid = 1'b0; pc_en = 1'b0;
        check("ill_accept_pc", pc, 16'h0010);
        step();
        check("ill_pulse", illegal, 1);
        check("ill_taken", taken, 0);
        check("ill_pc", pc, 16'h0010);
        check("ill_flush", flush, 0);
        step();
        check("ill_pulse_off", illegal, 0);

        // pc wrap: branch to 0xFFFF then increment during FLUSH.
        br_valid = 1'b1; br_cond = 3'b100; br_target = 16'hFFFF;
        step();
        br_valid = 1'b0;
        step();
        check("wrap_target", pc, 16'hFFFF);
        pc_en = 1'b1;
        step();
        pc_en = 1'b0;
        check("wrap_pc", pc, 16'h0000);
        step();
        check("wrap_ready", br_ready, 1);

        // Back-pressure: second request held through EVAL/FLUSH.
        accepts = 0;
        br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0050;
        step();
        br_target = 16'h0060;
        check("bp_eval_ready", br_ready, 0);
        step();
        check("bp_first_pc", pc, 16'h0050);
        check("bp_flush_ready", br_ready, 0);
        step();
        check("bp_flush2_ready", br_ready, 0);
        step();
        check("bp_idle_ready", br_ready, 1);
        check("bp_idle_pc", pc, 16'h0050);
        step();
        br_valid = 1'b0;
        check("bp_second_eval", br_ready, 0);
        step();
        check("bp_second_pc", pc, 16'h0060);
        check("bp_second_taken", taken, 1);
        step(); step(); step();
        check("bp_accepts", accepts, 2);
        check("bp_final_pc", pc, 16'h0060);

        // Async reset in the middle of FLUSH.
        flag_we = 1'b1; szcv_in = 4'b1011;
        step();
        flag_we = 1'b0;
        br_valid = 1'b1; br_cond = 3'b100; br_target = 16'h0080;
        step();
        br_valid = 1'b0;
        step();
        check("mid_flush", flush, 1);
        #2 rst = 1'b1;
        #1;
        check("async_pc", pc, 16'h0000);
        check("async_flush", flush, 0);
        check("async_flags", flags, 4'h0);
        step();
        rst = 1'b0;
        pc_en = 1'b1;
        step(); step(); step();
        pc_en = 1'b0;
        check("post_rst_pc", pc, 16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
